rd_status_sync: RTL and testbench
=================================

Name: rd_status_sync

Overview:
Read-domain receiver for the gray-coded write pointer of the asynchronous FIFO.
- Passes the write-domain gray pointer through a multi-flop synchronizer and decodes it back to binary.
- Compares it against the local binary read pointer and produces registered empty, almost_empty, fill count and a sticky pointer-error flag.
- Sits beside the read pointer logic; its empty output gates read-pointer increments.

Parameters:
PTR_WIDTH, 4, address bits; pointers are PTR_WIDTH+1 bits, DEPTH = 2**PTR_WIDTH
SYNC_STAGES, 2, number of synchronizer flops (legal 2..4)
AE_THRESH, 2, almost_empty asserted when fill count <= AE_THRESH (legal 0..DEPTH-1)

Ports:
rclk  input  1  read-domain clock; all state on posedge
rrst_n  input  1  asynchronous active-low reset
wptr_gray_async  input  PTR_WIDTH+1  gray write pointer from the write domain, unsynchronized
rptr_bin  input  PTR_WIDTH+1  local binary read pointer (registered, same rclk domain)
ren  input  1  read request this cycle
empty  output  1  registered FIFO empty flag
almost_empty  output  1  registered, fill count <= AE_THRESH
rd_count  output  PTR_WIDTH+1  registered fill level as seen by the read domain, 0..DEPTH
wptr_gray_sync  output  PTR_WIDTH+1  last synchronizer stage
wptr_bin_sync  output  PTR_WIDTH+1  binary decode of wptr_gray_sync (combinational from the register)
ptr_err  output  1  sticky: computed fill exceeded DEPTH

Behaviour:
Clock and reset:
- One clock, rclk. Reset is asynchronous, active-low (rrst_n); it asserts immediately and is released synchronously on an rclk edge.
- Reset values: all synchronizer stages 0; empty=1; almost_empty=1; rd_count=0; ptr_err=0; wptr_gray_sync=0, hence wptr_bin_sync=0.
- Reset mid-operation returns every output to its reset value on the same cycle; no state survives.

Synchronizer:
- SYNC_STAGES back-to-back flops on wptr_gray_async.
- No logic between stages; only the last stage is used downstream.

Gray decode:
- b[PTR_WIDTH] = g[PTR_WIDTH]; b[i] = b[i+1] ^ g[i] for i = PTR_WIDTH-1 down to 0.

Next read pointer:
- rptr_next = rptr_bin + (ren && !empty), modulo 2**(PTR_WIDTH+1).
- This matches the increment rule of the read pointer, so the flags track the pointer the read side holds after this edge.

Fill and flags, registered each rclk edge:
- fill_next = wptr_bin_sync - rptr_next, modulo 2**(PTR_WIDTH+1).
- empty <= (fill_next == 0), i.e. full (PTR_WIDTH+1)-bit equality including the wrap bit.
- rd_count <= fill_next when fill_next <= DEPTH; otherwise rd_count holds its value.
- almost_empty <= (fill_next <= AE_THRESH).
- ptr_err <= ptr_err | (fill_next > DEPTH). Cleared only by reset.

Latency:
- A write-pointer change at the input reaches wptr_gray_sync after SYNC_STAGES rclk edges.
- It reaches empty, almost_empty and rd_count one edge later (SYNC_STAGES+1 total).

Boundary conditions:
- Pessimism: empty may stay asserted longer than true occupancy (write side ahead of the synchronized copy). It never deasserts while the FIFO is truly empty.
- Read of last word: with fill 1 and ren=1, empty=1 on the next edge. There is no one-cycle window where a second read is accepted.
- ren while empty=1: ignored; rptr_next = rptr_bin; flags unchanged unless the write pointer advanced.
- Wrap-around: pointers differing only in the MSB give fill_next = DEPTH. That is legal (full), with empty=0 and rd_count=DEPTH.
- Simultaneous write-pointer advance and read: both are folded into fill_next in the same cycle.
- Several write increments between samples (fast wclk) are legal; the decode simply jumps.

Test Plan:
(All scenarios use PTR_WIDTH=4, SYNC_STAGES=2, AE_THRESH=2.)
1. Reset: drive wptr_gray_async=5'b00110 with rrst_n low -> empty=1, almost_empty=1, rd_count=0, ptr_err=0, wptr_gray_sync=0. Release reset, hold rptr_bin=0 -> empty falls on the 3rd rclk edge, rd_count=4, wptr_bin_sync=4.
2. Latency: step wptr_gray_async 0->1 at an edge with rptr_bin=0 -> wptr_gray_sync=1 after 2 edges; empty 1->0, rd_count=1, almost_empty=1 after 3 edges.
3. Drain to empty: fill 3 (wptr_bin_sync=3), read every cycle with rptr_bin tracking increments -> rd_count 2,1,0; almost_empty=1 from fill 2; empty=1 on the edge consuming word 3. Further ren gives rptr_next unchanged.
4. Wrap and full: rptr_bin=5'b01111 and wptr_bin_sync=5'b11111 (gray 5'b10000) -> empty=0, rd_count=16, ptr_err=0. Then read across the wrap to rptr_bin=5'b10000 -> rd_count=15.
5. Simultaneous events: fill 1 with ren=1, and the write pointer advancing by 2 in the same sync cycle -> rd_count=2, empty stays 0, almost_empty=1.
6. Error: force wptr_bin_sync - rptr_bin = 20 (rptr_bin=0, wptr gray of 20) -> ptr_err=1 and stays 1 after legal pointers resume; rd_count holds its last legal value; rrst_n low clears ptr_err.

Source files
------------

// File: rtl/rd_status_sync.sv
// Read-domain status for the async FIFO: synchronizes the gray write pointer,
// decodes it, and derives registered empty / almost_empty / fill / error flags.
module rd_status_sync #(
   parameter int PTR_WIDTH   = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AE_THRESH   = 2
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic [PTR_WIDTH:0]   wptr_gray_async,
   input  logic [PTR_WIDTH:0]   rptr_bin,
   input  logic                 ren,
   output logic                 empty,
   output logic                 almost_empty,
   output logic [PTR_WIDTH:0]   rd_count,
   output logic [PTR_WIDTH:0]   wptr_gray_sync,
   output logic [PTR_WIDTH:0]   wptr_bin_sync,
   output logic                 ptr_err
);

   localparam int              PW       = PTR_WIDTH + 1;
   localparam logic [PW-1:0]   DEPTH    = PW'(2 ** PTR_WIDTH);
   localparam logic [PW-1:0]   AE_LIMIT = PW'(AE_THRESH);

   logic [PW-1:0] sync_q [SYNC_STAGES];
   logic          rd_step;
   logic [PW-1:0] rptr_next;
   logic [PW-1:0] fill_next;
   logic          fill_over;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= wptr_gray_async;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign wptr_gray_sync = sync_q[SYNC_STAGES-1];

   // Each binary bit is the XOR of all gray bits at or above it.
   always_comb begin
      wptr_bin_sync = '0;
      for (int i = 0; i < PW; i++) begin
         wptr_bin_sync[i] = ^(wptr_gray_sync >> i);
      end
   end

   // Mirrors the read pointer's own increment so flags describe the post-edge pointer.
   assign rd_step   = ren && !empty;
   assign rptr_next = rptr_bin + PW'(rd_step);
   assign fill_next = wptr_bin_sync - rptr_next;
   assign fill_over = (fill_next > DEPTH);

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_count     <= '0;
         ptr_err      <= 1'b0;
      end else begin
         empty        <= (fill_next == '0);
         almost_empty <= (fill_next <= AE_LIMIT);
         if (!fill_over) begin
            rd_count <= fill_next;
         end
         ptr_err      <= ptr_err | fill_over;
      end
   end

endmodule

// File: tb/tb_rd_status_sync.sv
// Bench for rd_status_sync: reset/latency sequences plus a per-cycle vector table
// whose expected outputs flow through a scoreboard queue.
module tb_rd_status_sync;

   logic       rclk;
   logic       rrst_n;
   logic [4:0] wptr_gray_async;
   logic [4:0] rptr_bin;
   logic       ren;
   logic       empty;
   logic       almost_empty;
   logic [4:0] rd_count;
   logic [4:0] wptr_gray_sync;
   logic [4:0] wptr_bin_sync;
   logic       ptr_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] w;
      logic [4:0] r;
      logic       rd;
      logic       e;
      logic       ae;
      logic [4:0] cnt;
      logic       err;
   } vec_t;

   typedef struct {
      int         idx;
      logic       e;
      logic       ae;
      logic [4:0] cnt;
      logic       err;
      logic [4:0] wbin;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   rd_status_sync #(
      .PTR_WIDTH   (4),
      .SYNC_STAGES (2),
      .AE_THRESH   (2)
   ) dut (
      .rclk            (rclk),
      .rrst_n          (rrst_n),
      .wptr_gray_async (wptr_gray_async),
      .rptr_bin        (rptr_bin),
      .ren             (ren),
      .empty           (empty),
      .almost_empty    (almost_empty),
      .rd_count        (rd_count),
      .wptr_gray_sync  (wptr_gray_sync),
      .wptr_bin_sync   (wptr_bin_sync),
      .ptr_err         (ptr_err)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [4:0] to_gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input int w, input int r, input bit rd, input bit e,
                          input bit ae, input int cnt, input bit err);
      vec_t v;
      v.w = 5'(w); v.r = 5'(r); v.rd = rd;
      v.e = e; v.ae = ae; v.cnt = 5'(cnt); v.err = err;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   initial begin
      exp_t       x;
      logic [4:0] prev_w;

      // w, r, ren | empty, almost_empty, rd_count, ptr_err
      add_vec( 1,  0, 0, 1, 1,  0, 0);
      add_vec( 1,  0, 0, 1, 1,  0, 0);
      add_vec( 1,  0, 0, 0, 1,  1, 0);
      add_vec( 3,  0, 0, 0, 1,  1, 0);
      add_vec( 3,  0, 0, 0, 1,  1, 0);
      add_vec( 3,  0, 0, 0, 0,  3, 0);
      add_vec( 3,  0, 1, 0, 1,  2, 0);
      add_vec( 3,  1, 1, 0, 1,  1, 0);
      add_vec( 3,  2, 1, 1, 1,  0, 0);
      add_vec( 3,  3, 1, 1, 1,  0, 0);
      add_vec( 4,  3, 0, 1, 1,  0, 0);
      add_vec( 4,  3, 0, 1, 1,  0, 0);
      add_vec( 4,  3, 0, 0, 1,  1, 0);
      add_vec( 6,  3, 0, 0, 1,  1, 0);
      add_vec( 6,  3, 0, 0, 1,  1, 0);
      add_vec( 6,  3, 1, 0, 1,  2, 0);
      add_vec(19,  4, 0, 0, 1,  2, 0);
      add_vec(19,  4, 0, 0, 1,  2, 0);
      add_vec(19,  4, 0, 0, 0, 15, 0);
      add_vec(19, 15, 0, 0, 0,  4, 0);
      add_vec(31, 15, 0, 0, 0,  4, 0);
      add_vec(31, 15, 0, 0, 0,  4, 0);
      add_vec(31, 15, 0, 0, 0, 16, 0);
      add_vec(31, 15, 1, 0, 0, 15, 0);
      add_vec(31, 16, 0, 0, 0, 15, 0);
      add_vec(20, 16, 0, 0, 0, 15, 0);
      add_vec(20, 16, 0, 0, 0, 15, 0);
      add_vec(20, 16, 0, 0, 0,  4, 0);
      add_vec(20,  0, 0, 0, 0,  4, 1);
      add_vec(20, 16, 0, 0, 0,  4, 1);
      add_vec(21, 16, 0, 0, 0,  4, 1);

      // Reset with a nonzero write pointer pending at the input.
      rrst_n          = 1'b0;
      wptr_gray_async = 5'b00110;
      rptr_bin        = 5'd0;
      ren             = 1'b0;
      repeat (3) tick();
      chk("rst.empty",        32'(empty),          32'd1);
      chk("rst.almost_empty", 32'(almost_empty),   32'd1);
      chk("rst.rd_count",     32'(rd_count),       32'd0);
      chk("rst.ptr_err",      32'(ptr_err),        32'd0);
      chk("rst.gray_sync",    32'(wptr_gray_sync), 32'd0);

      rrst_n = 1'b1;
      tick();
      chk("rel1.empty",     32'(empty),          32'd1);
      chk("rel1.gray_sync", 32'(wptr_gray_sync), 32'd0);
      tick();
      chk("rel2.empty",     32'(empty),          32'd1);
      chk("rel2.gray_sync", 32'(wptr_gray_sync), 32'd6);
      chk("rel2.bin_sync",  32'(wptr_bin_sync),  32'd4);
      tick();
      chk("rel3.empty",        32'(empty),        32'd0);
      chk("rel3.rd_count",     32'(rd_count),     32'd4);
      chk("rel3.almost_empty", 32'(almost_empty), 32'd0);

      // Asynchronous reset mid-operation takes effect without a clock edge.
      rrst_n          = 1'b0;
      wptr_gray_async = 5'd0;
      #1;
      chk("midrst.empty",     32'(empty),          32'd1);
      chk("midrst.rd_count",  32'(rd_count),       32'd0);
      chk("midrst.ae",        32'(almost_empty),   32'd1);
      chk("midrst.gray_sync", 32'(wptr_gray_sync), 32'd0);
      tick();
      rrst_n = 1'b1;

      prev_w = 5'd0;
      for (int i = 0; i < vecs.size(); i++) begin
         wptr_gray_async = to_gray(vecs[i].w);
         rptr_bin        = vecs[i].r;
         ren             = vecs[i].rd;
         x.idx  = i;
         x.e    = vecs[i].e;
         x.ae   = vecs[i].ae;
         x.cnt  = vecs[i].cnt;
         x.err  = vecs[i].err;
         x.wbin = prev_w;
         sb.push_back(x);
         prev_w = vecs[i].w;
         tick();
         if (sb.size() == 0) begin
            chk($sformatf("v%0d.scoreboard_empty", i), 32'd1, 32'd0);
         end else begin
            x = sb.pop_front();
            chk($sformatf("v%0d.empty", x.idx),        32'(empty),          32'(x.e));
            chk($sformatf("v%0d.almost_empty", x.idx), 32'(almost_empty),   32'(x.ae));
            chk($sformatf("v%0d.rd_count", x.idx),     32'(rd_count),       32'(x.cnt));
            chk($sformatf("v%0d.ptr_err", x.idx),      32'(ptr_err),        32'(x.err));
            chk($sformatf("v%0d.bin_sync", x.idx),     32'(wptr_bin_sync),  32'(x.wbin));
            chk($sformatf("v%0d.gray_sync", x.idx),    32'(wptr_gray_sync), 32'(to_gray(x.wbin)));
         end
      end

      // Only reset clears the sticky error.
      rrst_n = 1'b0;
      #1;
      chk("errclr.ptr_err",  32'(ptr_err),  32'd0);
      chk("errclr.empty",    32'(empty),    32'd1);
      chk("errclr.rd_count", 32'(rd_count), 32'd0);
      tick();
      rrst_n          = 1'b1;
      wptr_gray_async = 5'd0;
      rptr_bin        = 5'd0;
      ren             = 1'b1;
      tick();
      chk("post.ptr_err", 32'(ptr_err), 32'd0);
      chk("post.empty",   32'(empty),   32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
